// File: rtl/inst_encoder_pkg.sv
// Shared constants for the RV32I instruction encoder: symbolic op codes,
// base opcodes, FSM state type and the funct3 lookup.
package inst_encoder_pkg;

  localparam logic [5:0] OP_LUI   = 6'd0;
  localparam logic [5:0] OP_AUIPC = 6'd1;
  localparam logic [5:0] OP_JAL   = 6'd2;
  localparam logic [5:0] OP_JALR  = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BGEU  = 6'd9;
  localparam logic [5:0] OP_LB    = 6'd10;
  localparam logic [5:0] OP_LHU   = 6'd14;
  localparam logic [5:0] OP_SB    = 6'd15;
  localparam logic [5:0] OP_SW    = 6'd17;
  localparam logic [5:0] OP_ADDI  = 6'd18;
  localparam logic [5:0] OP_ANDI  = 6'd23;
  localparam logic [5:0] OP_SLLI  = 6'd24;
  localparam logic [5:0] OP_SRAI  = 6'd26;
  localparam logic [5:0] OP_ADD   = 6'd27;
  localparam logic [5:0] OP_SUB   = 6'd28;
  localparam logic [5:0] OP_SRA   = 6'd34;
  localparam logic [5:0] OP_AND   = 6'd36;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FULL} state_e;

  // funct3 for every symbolic op; ops without a funct3 field fall to 0
  function automatic logic [2:0] funct3_of(input logic [5:0] op);
    case (op)
      6'd5, 6'd11, 6'd16, 6'd24, 6'd29:        funct3_of = 3'd1;
      6'd12, 6'd17, 6'd19, 6'd30:              funct3_of = 3'd2;
      6'd20, 6'd31:                            funct3_of = 3'd3;
      6'd6, 6'd13, 6'd21, 6'd32:               funct3_of = 3'd4;
      6'd7, 6'd14, 6'd25, 6'd26, 6'd33, 6'd34: funct3_of = 3'd5;
      6'd8, 6'd22, 6'd35:                      funct3_of = 3'd6;
      6'd9, 6'd23, 6'd36:                      funct3_of = 3'd7;
      default:                                 funct3_of = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational packer: symbolic request -> 32-bit RV32I word plus a legality flag.
module inst_pack
  import inst_encoder_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  logic       fit_i, fit_b, fit_j;
  logic [2:0] f3;

  // A range check is a sign-extension check: all bits above the field agree
  assign fit_i = (&imm[31:11]) | ~(|imm[31:11]);
  assign fit_b = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign fit_j = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign f3    = funct3_of(op);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op) inside
      OP_LUI, OP_AUIPC: begin
        legal = ~(|imm[11:0]);
        word  = {imm[31:12], rd, (op == OP_LUI) ? OPC_LUI : OPC_AUIPC};
      end
      OP_JAL: begin
        legal = fit_j;
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      end
      OP_JALR: begin
        legal = fit_i;
        word  = {imm[11:0], rs1, f3, rd, OPC_JALR};
      end
      [OP_BEQ:OP_BGEU]: begin
        legal = fit_b;
        word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
      end
      [OP_LB:OP_LHU]: begin
        legal = fit_i;
        word  = {imm[11:0], rs1, f3, rd, OPC_LOAD};
      end
      [OP_SB:OP_SW]: begin
        legal = fit_i;
        word  = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
      end
      [OP_ADDI:OP_ANDI]: begin
        legal = fit_i;
        word  = {imm[11:0], rs1, f3, rd, OPC_OPIMM};
      end
      [OP_SLLI:OP_SRAI]: begin
        legal = ~(|imm[31:5]);
        word  = {1'b0, op == OP_SRAI, 5'b0, imm[4:0], rs1, f3, rd, OPC_OPIMM};
      end
      [OP_ADD:OP_AND]: begin
        word  = {1'b0, (op == OP_SUB) || (op == OP_SRA), 5'b0, rs2, rs1, f3, rd, OPC_OP};
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder / program writer: accepts symbolic requests and writes
// the encoded words sequentially into instruction memory.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [31:0]       wdata_q, wdata_d, word;
  logic              err_q, err_d, we_q, we_d;
  logic              legal, accept;

  inst_pack u_pack (
    .op    (in_op),
    .rd    (in_rd),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .imm   (in_imm),
    .word  (word),
    .legal (legal)
  );

  // start wins over a concurrent request, so it also masks ready
  assign in_ready = (state_q == ST_RUN) && !start;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (start) begin
      state_d = ST_RUN;
      ptr_d   = BASE;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (accept) begin
      if (legal) begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = word;
        ptr_d   = ptr_q + 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (ptr_q == '1) state_d = ST_FULL;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= BASE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign err      = err_q;
  assign count    = cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed program plus random requests,
// checked against an arithmetic reference encoder and a small writer model.
module tb_inst_encoder;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, in_valid = 1'b0;
  logic          in_ready;
  logic [5:0]    in_op = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0]   in_imm = '0;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          err;
  logic [AW:0]   count;

  inst_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   word;
    int            stamp;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0, cyc_n = 0;

  // writer model
  bit m_run = 0, m_full = 0, m_err = 0;
  int m_ptr = 0, m_cnt = 0;

  int br_f3[6]   = '{0, 1, 4, 5, 6, 7};
  int ld_f3[5]   = '{0, 1, 2, 4, 5};
  int alui_f3[6] = '{0, 2, 3, 4, 6, 7};
  int sh_f3[3]   = '{1, 5, 5};
  int r_f3[10]   = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  int edges[16]  = '{-1048578, -1048576, 1048574, 1048575, -4096, -4098, 4094, 4096,
                     -2048, -2049, 2047, 2048, 31, 32, -1, 0};

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // Reference encoder built from the RV32I field layouts with integer arithmetic
  function automatic logic [31:0] ref_enc(input int op, input int rd, input int rs1,
                                          input int rs2, input int imm, output bit ok);
    int unsigned u, w, regs_i, bit12, bit11;
    bit in12;
    u      = imm;
    w      = 0;
    ok     = 1;
    in12   = (imm >= -2048) && (imm <= 2047);
    regs_i = (rs1 << 15) | (rd << 7);
    bit12  = (u >> 12) & 1;
    bit11  = (u >> 11) & 1;
    if (op == 0 || op == 1) begin
      ok = (u % 4096) == 0;
      w  = (u & 32'hFFFFF000) | (rd << 7) | ((op == 0) ? 32'h37 : 32'h17);
    end else if (op == 2) begin
      ok = (u % 2 == 0) && (imm >= -1048576) && (imm <= 1048574);
      w  = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (bit11 << 20)
         | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
    end else if (op == 3) begin
      ok = in12;
      w  = ((u & 32'hFFF) << 20) | regs_i | 32'h67;
    end else if (op >= 4 && op <= 9) begin
      ok = (u % 2 == 0) && (imm >= -4096) && (imm <= 4094);
      w  = (bit12 << 31) | (((u >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
         | (br_f3[op-4] << 12) | (((u >> 1) & 15) << 8) | (bit11 << 7) | 32'h63;
    end else if (op >= 10 && op <= 14) begin
      ok = in12;
      w  = ((u & 32'hFFF) << 20) | regs_i | (ld_f3[op-10] << 12) | 32'h03;
    end else if (op >= 15 && op <= 17) begin
      ok = in12;
      w  = (((u >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | ((op - 15) << 12)
         | ((u & 31) << 7) | 32'h23;
    end else if (op >= 18 && op <= 23) begin
      ok = in12;
      w  = ((u & 32'hFFF) << 20) | regs_i | (alui_f3[op-18] << 12) | 32'h13;
    end else if (op >= 24 && op <= 26) begin
      ok = (imm >= 0) && (imm <= 31);
      w  = ((op == 26) ? (32'h1 << 30) : 32'h0) | ((u & 31) << 20) | regs_i
         | (sh_f3[op-24] << 12) | 32'h13;
    end else if (op >= 27 && op <= 36) begin
      w  = ((op == 28 || op == 34) ? (32'h1 << 30) : 32'h0) | (rs2 << 20) | regs_i
         | (r_f3[op-27] << 12) | 32'h33;
    end else begin
      ok = 0;
    end
    return w;
  endfunction

  // One clock of stimulus; the model decides acceptance and queues the expected write
  task automatic cyc(input bit st, input bit v, input int op, input int rd, input int rs1,
                     input int rs2, input int imm, input bit use_exp, input logic [31:0] exp_w);
    bit rdy, ok;
    logic [31:0] w;
    exp_t e;
    @(negedge clk);
    start    = st;
    in_valid = v;
    in_op    = op[5:0];
    in_rd    = rd[4:0];
    in_rs1   = rs1[4:0];
    in_rs2   = rs2[4:0];
    in_imm   = imm;
    rdy = m_run && !m_full && !st;
    #1 chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    @(posedge clk);
    #1;
    if (st) begin
      m_run = 1; m_full = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
    end else if (v && rdy) begin
      w = ref_enc(op, rd, rs1, rs2, imm, ok);
      if (use_exp) w = exp_w;
      if (ok) begin
        e.addr = m_ptr[AW-1:0]; e.word = w; e.stamp = cyc_n;
        q.push_back(e);
        if (m_ptr == (1 << AW) - 1) m_full = 1;
        m_ptr = (m_ptr + 1) % (1 << AW);
        m_cnt++;
      end else begin
        m_err = 1;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk("err", {31'b0, err}, {31'b0, m_err});
    chk("count", 32'(count), m_cnt);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int rnd_imm();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 127)) - 64;
      1:       return edges[$urandom_range(0, 15)];
      2:       return int'($urandom & 32'hFFFFF000);
      default: return int'($urandom);
    endcase
  endfunction

  // Monitor: every IM write must match the head of the scoreboard, one cycle after acceptance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (im_we === 1'b1) begin
        if (q.size() == 0) begin
          chk("im_we_unexpected", {31'b0, im_we}, 32'h0);
        end else begin
          e = q.pop_front();
          chk("wr_addr", 32'(im_addr), 32'(e.addr));
          chk("wr_data", im_wdata, e.word);
          chk("wr_latency", cyc_n, e.stamp);
        end
      end
    end
  end

  initial begin
    int op, imm;
    bit st, v;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_im_we", {31'b0, im_we}, 0);
    chk("rst_im_addr", 32'(im_addr), 0);
    chk("rst_im_wdata", im_wdata, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_count", 32'(count), 0);
    rst = 1'b0;
    idle();

    // First program, back-to-back with known encodings
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 18, 1, 0, 0, 5, 1, 32'h00500093);
    cyc(0, 1, 0, 2, 0, 0, 32'h12345000, 1, 32'h12345137);
    cyc(0, 1, 2, 1, 0, 0, 8, 1, 32'h008000EF);
    cyc(0, 1, 17, 0, 2, 5, 12, 1, 32'h00512623);
    cyc(0, 1, 4, 0, 1, 2, -4, 1, 32'hFE208EE3);

    // Illegal requests are consumed without writing
    cyc(0, 1, 40, 1, 1, 1, 0, 0, 0);
    cyc(0, 1, 18, 1, 1, 0, 2048, 0, 0);
    cyc(0, 1, 4, 0, 1, 2, 3, 0, 0);
    cyc(0, 1, 24, 3, 4, 0, 32, 0, 0);
    idle();

    // start beats a concurrent request and clears err
    cyc(1, 1, 18, 7, 7, 0, 1, 0, 0);
    cyc(0, 1, 18, 2, 0, 0, -1, 1, 32'hFFF00113);

    // Fill the whole memory, then keep offering a request
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < (1 << AW) + 1; i++) cyc(0, 1, 18, i % 32, 0, 0, i, 0, 0);
    idle();

    // start while the previous write is still on the bus
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 27, 3, 1, 2, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 28, 3, 1, 2, 0, 0, 0);

    // Reset between acceptance and write cycle drops the write
    cyc(0, 1, 18, 1, 0, 0, 5, 0, 0);
    rst = 1'b1;
    chk("inflight_queued", q.size(), 1);
    q.delete();
    m_run = 0; m_full = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
    @(negedge clk);
    #1;
    chk("midrst_im_we", {31'b0, im_we}, 0);
    chk("midrst_in_ready", {31'b0, in_ready}, 0);
    chk("midrst_count", 32'(count), 0);
    rst = 1'b0;
    idle();

    // Random traffic
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      st  = m_full ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 60) == 0);
      v   = $urandom_range(0, 9) != 0;
      op  = $urandom_range(0, 42);
      imm = rnd_imm();
      if (op <= 1 && $urandom_range(0, 1) == 1) imm = int'(imm & 32'hFFFFF000);
      cyc(st, v, op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
          imm, 0, 0);
    end
    idle();
    idle();
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
